move_controller: RTL and testbench



---
 rtl/move_controller_if.sv | 29 ++
 rtl/move_controller.sv | 166 ++++++++++++++++
 tb/tb_move_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/move_controller_if.sv
// Button/collision inputs and step/load outputs between the move controller
// and its surroundings; the controller takes the master side.
interface move_controller_if;
  logic       btn_l;
  logic       btn_r;
  logic       btn_u;
  logic       btn_d;
  logic       start;
  logic       edge_collision;
  logic       l;
  logic       r;
  logic       u;
  logic       d;
  logic       load;
  logic [2:0] load_x;
  logic [2:0] load_y;
  logic [1:0] heading;
  logic [1:0] state;

  modport master (
    input  btn_l, btn_r, btn_u, btn_d, start, edge_collision,
    output l, r, u, d, load, load_x, load_y, heading, state
  );

  modport slave (
    output btn_l, btn_r, btn_u, btn_d, start, edge_collision,
    input  l, r, u, d, load, load_x, load_y, heading, state
  );
endinterface

// File: rtl/move_controller.sv
// Snake move controller: turns button presses into one-hot step pulses at a fixed
// rate, and handles start/respawn loading and stopping on edge collision.
module move_controller #(
  parameter int         TICK_DIV = 25000000,
  parameter int         TICK_W   = 25,
  parameter logic [2:0] START_X  = 3'd3,
  parameter logic [2:0] START_Y  = 3'd3
) (
  input  logic              clk,
  input  logic              reset,
  move_controller_if.master mc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DEAD = 2'b11
  } state_e;

  localparam logic [1:0]        DIR_R    = 2'b00;
  localparam logic [1:0]        DIR_L    = 2'b01;
  localparam logic [1:0]        DIR_U    = 2'b10;
  localparam logic [1:0]        DIR_D    = 2'b11;
  localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] CNT_ONE  = TICK_W'(1);

  state_e            state_q;
  logic [TICK_W-1:0] cnt_q;
  logic [1:0]        heading_q;
  logic              pend_valid_q;
  logic [1:0]        pend_dir_q;
  logic [3:0]        hist_q;
  logic              l_q;
  logic              r_q;
  logic              u_q;
  logic              d_q;
  logic              load_q;
  logic [2:0]        load_x_q;
  logic [2:0]        load_y_q;

  logic [3:0] btn_s;
  logic [3:0] rise_s;
  logic       req_valid_s;
  logic [1:0] req_dir_s;
  logic       accept_s;
  logic       pend_valid_d;
  logic [1:0] pend_dir_d;
  logic [1:0] step_heading_s;
  logic       tick_s;

  // Button vector ordered {l, r, u, d}, so bit 3 carries the highest priority.
  assign btn_s  = {mc.btn_l, mc.btn_r, mc.btn_u, mc.btn_d};
  assign rise_s = btn_s & ~hist_q;
  assign tick_s = (cnt_q == CNT_LAST);

  // Priority-select one request among simultaneous rising edges.
  always_comb begin
    req_valid_s = 1'b0;
    req_dir_s   = DIR_R;
    if (rise_s[3]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_L;
    end else if (rise_s[2]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_R;
    end else if (rise_s[1]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_U;
    end else if (rise_s[0]) begin
      req_valid_s = 1'b1;
      req_dir_s   = DIR_D;
    end else begin
      req_valid_s = 1'b0;
      req_dir_s   = DIR_R;
    end
  end

  // Opposite direction differs only in bit 0 (r<->l, u<->d); newest accepted press wins.
  assign accept_s       = req_valid_s && (req_dir_s != (heading_q ^ 2'b01));
  assign pend_valid_d   = accept_s | pend_valid_q;
  assign pend_dir_d     = accept_s ? req_dir_s : pend_dir_q;
  assign step_heading_s = pend_valid_d ? pend_dir_d : heading_q;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      heading_q    <= DIR_R;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_R;
      hist_q       <= 4'b0000;
      l_q          <= 1'b0;
      r_q          <= 1'b0;
      u_q          <= 1'b0;
      d_q          <= 1'b0;
      load_q       <= 1'b0;
      load_x_q     <= START_X;
      load_y_q     <= START_Y;
    end else begin
      hist_q   <= btn_s;
      l_q      <= 1'b0;
      r_q      <= 1'b0;
      u_q      <= 1'b0;
      d_q      <= 1'b0;
      load_q   <= 1'b0;
      load_x_q <= START_X;
      load_y_q <= START_Y;
      case (state_q)
        ST_IDLE, ST_DEAD: begin
          pend_valid_q <= 1'b0;
          cnt_q        <= '0;
          if (mc.start) begin
            state_q   <= ST_LOAD;
            load_q    <= 1'b1;
            heading_q <= DIR_R;
          end else begin
            state_q <= state_q;
          end
        end
        ST_LOAD: begin
          state_q      <= ST_RUN;
          heading_q    <= DIR_R;
          cnt_q        <= '0;
          pend_valid_q <= 1'b0;
        end
        ST_RUN: begin
          if (mc.edge_collision) begin
            state_q      <= ST_DEAD;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
          end else if (tick_s) begin
            cnt_q        <= '0;
            heading_q    <= step_heading_s;
            pend_valid_q <= 1'b0;
            r_q          <= (step_heading_s == DIR_R);
            l_q          <= (step_heading_s == DIR_L);
            u_q          <= (step_heading_s == DIR_U);
            d_q          <= (step_heading_s == DIR_D);
          end else begin
            cnt_q        <= cnt_q + CNT_ONE;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= '0;
          pend_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mc.l       = l_q;
  assign mc.r       = r_q;
  assign mc.u       = u_q;
  assign mc.d       = d_q;
  assign mc.load    = load_q;
  assign mc.load_x  = load_x_q;
  assign mc.load_y  = load_y_q;
  assign mc.heading = heading_q;
  assign mc.state   = state_q;

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller with TICK_DIV=4: expected pulse/load events
// and scheduled status snapshots are queued up front and checked by a monitor.
module tb_move_controller;

  typedef struct packed {
    int         cyc;
    logic [3:0] lrud;
    logic       load;
    logic [1:0] hd;
    logic [1:0] st;
    logic [2:0] lx;
    logic [2:0] ly;
  } snap_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;
  bit   done;
  bit   done_chk;
  int   base;
  snap_t ev_q[$];
  snap_t chk_q[$];
  snap_t act;
  snap_t expv;

  move_controller_if mc ();

  move_controller #(
    .TICK_DIV(4),
    .TICK_W  (3),
    .START_X (3'd3),
    .START_Y (3'd3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mc   (mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk(int c, logic [3:0] lrud, logic ld, logic [1:0] hd, logic [1:0] st);
    snap_t s;
    s.cyc  = c;
    s.lrud = lrud;
    s.load = ld;
    s.hd   = hd;
    s.st   = st;
    s.lx   = 3'd3;
    s.ly   = 3'd3;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("cyc=%0d lrud=%b load=%b heading=%b state=%b load_xy=%0d,%0d",
                     s.cyc, s.lrud, s.load, s.hd, s.st, s.lx, s.ly);
  endfunction

  // Monitor: every step/load output pops the event queue; scheduled snapshots checked by cycle.
  initial begin
    n_vec    = 0;
    n_bad    = 0;
    done_chk = 1'b0;
    forever begin
      @(negedge clk);
      act = mk(cyc, {mc.l, mc.r, mc.u, mc.d}, mc.load, mc.heading, mc.state);
      act.lx = mc.load_x;
      act.ly = mc.load_y;
      if (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        expv = chk_q.pop_front();
        n_vec++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL snapshot: got %s, required %s", fmt(act), fmt(expv));
        end
      end
      if (mc.l || mc.r || mc.u || mc.d || mc.load) begin
        n_vec++;
        if (ev_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got %s, required no event", fmt(act));
        end else begin
          expv = ev_q.pop_front();
          if (act !== expv) begin
            n_bad++;
            $display("FAIL event: got %s, required %s", fmt(act), fmt(expv));
          end
        end
      end
      if (done && !done_chk) begin
        done_chk = 1'b1;
        n_vec++;
        if (ev_q.size() != 0 || chk_q.size() != 0) begin
          n_bad++;
          $display("FAIL leftover: got %0d events and %0d snapshots pending, required 0 and 0",
                   ev_q.size(), chk_q.size());
        end
      end
    end
  end

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    done              = 1'b0;
    reset             = 1'b1;
    mc.btn_l          = 1'b0;
    mc.btn_r          = 1'b0;
    mc.btn_u          = 1'b0;
    mc.btn_d          = 1'b0;
    mc.start          = 1'b0;
    mc.edge_collision = 1'b0;

    chk_q.push_back(mk(2, 4'b0000, 1'b0, 2'b00, 2'b00));
    chk_q.push_back(mk(4, 4'b0000, 1'b0, 2'b00, 2'b00));
    wait_cyc(3);
    reset = 1'b0;

    // Load appears at base; counter phase during cycle X in RUN is (X-base-1) mod 4.
    base = 7;
    ev_q.push_back(mk(base,      4'b0000, 1'b1, 2'b00, 2'b01));
    ev_q.push_back(mk(base + 5,  4'b0100, 1'b0, 2'b00, 2'b10));
    ev_q.push_back(mk(base + 9,  4'b0100, 1'b0, 2'b00, 2'b10));
    ev_q.push_back(mk(base + 13, 4'b0010, 1'b0, 2'b10, 2'b10));
    ev_q.push_back(mk(base + 17, 4'b0010, 1'b0, 2'b10, 2'b10));
    ev_q.push_back(mk(base + 21, 4'b0010, 1'b0, 2'b10, 2'b10));
    for (int k = 0; k < 6; k++)
      ev_q.push_back(mk(base + 25 + 4 * k, 4'b1000, 1'b0, 2'b01, 2'b10));
    ev_q.push_back(mk(base + 71, 4'b0000, 1'b1, 2'b00, 2'b01));
    ev_q.push_back(mk(base + 76, 4'b0100, 1'b0, 2'b00, 2'b10));
    ev_q.push_back(mk(base + 80, 4'b0100, 1'b0, 2'b00, 2'b10));

    chk_q.push_back(mk(base + 2,   4'b0000, 1'b0, 2'b00, 2'b10));
    chk_q.push_back(mk(base + 49,  4'b0000, 1'b0, 2'b01, 2'b11));
    chk_q.push_back(mk(base + 70,  4'b0000, 1'b0, 2'b01, 2'b11));
    chk_q.push_back(mk(base + 72,  4'b0000, 1'b0, 2'b00, 2'b10));
    chk_q.push_back(mk(base + 83,  4'b0000, 1'b0, 2'b00, 2'b00));
    chk_q.push_back(mk(base + 86,  4'b0000, 1'b0, 2'b00, 2'b00));
    chk_q.push_back(mk(base + 100, 4'b0000, 1'b0, 2'b00, 2'b00));

    wait_cyc(base - 1);
    mc.start = 1'b1;
    wait_cyc(base);
    mc.start = 1'b0;

    // Turn up, then a rejected reversal to down.
    wait_cyc(base + 10);
    mc.btn_u = 1'b1;
    wait_cyc(base + 11);
    mc.btn_u = 1'b0;
    wait_cyc(base + 14);
    mc.btn_d = 1'b1;
    wait_cyc(base + 15);
    mc.btn_d = 1'b0;

    // Simultaneous l and u: l wins; both then held.
    wait_cyc(base + 22);
    mc.btn_l = 1'b1;
    mc.btn_u = 1'b1;
    wait_cyc(base + 42);
    mc.btn_l = 1'b0;
    mc.btn_u = 1'b0;

    // Collision on the counter==3 cycle suppresses the step.
    wait_cyc(base + 48);
    mc.edge_collision = 1'b1;
    wait_cyc(base + 49);
    mc.edge_collision = 1'b0;
    wait_cyc(base + 55);
    mc.edge_collision = 1'b1;
    mc.btn_r          = 1'b1;
    wait_cyc(base + 56);
    mc.edge_collision = 1'b0;
    mc.btn_r          = 1'b0;

    // Respawn.
    wait_cyc(base + 70);
    mc.start = 1'b1;
    wait_cyc(base + 71);
    mc.start = 1'b0;

    // Asynchronous reset in the cycle before a step.
    wait_cyc(base + 82);
    @(posedge clk);
    #2;
    reset = 1'b1;
    wait_cyc(base + 85);
    reset = 1'b0;

    // Buttons in IDLE do nothing.
    wait_cyc(base + 88);
    mc.btn_r = 1'b1;
    wait_cyc(base + 90);
    mc.btn_u = 1'b1;
    wait_cyc(base + 92);
    mc.btn_r = 1'b0;
    mc.btn_u = 1'b0;

    wait_cyc(base + 105);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
